// File: rtl/imem_seq_pkg.sv
// Shared types and constants for the instruction-memory program sequencer.
package imem_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_WORD = 32'h00000013;

    // Index and length widths for the default 16-entry program store.
    localparam int unsigned IDX_W_DEFAULT = 4;
    localparam int unsigned LEN_W_DEFAULT = 5;

    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // One extra bit so a full-depth program length is representable.
    function automatic int unsigned len_width(input int unsigned depth);
        return idx_width(depth) + 1;
    endfunction

endpackage

// File: rtl/imem_seq_prog_mem.sv
// Program store: synchronous write, combinational read. Write gating lives in the parent.
module imem_seq_prog_mem
    import imem_seq_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned WORD_SIZE = 32
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [idx_width(DEPTH)-1:0] waddr,
    input  logic [WORD_SIZE-1:0]        wdata,
    input  logic [idx_width(DEPTH)-1:0] raddr,
    output logic [WORD_SIZE-1:0]        rdata
);

    logic [WORD_SIZE-1:0] mem [DEPTH];

    // Write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_program_sequencer.sv
// Handshaked program issue engine feeding the core's imem_resp port, followed by a
// NOP drain. Optional replay of the program is enabled by defining IMEM_SEQ_LOOP_EN.
module imem_program_sequencer
    import imem_seq_pkg::*;
#(
    parameter int unsigned           DEPTH        = 16,
    parameter int unsigned           WORD_SIZE    = 32,
    parameter int unsigned           DRAIN_CYCLES = 5,
    parameter logic [WORD_SIZE-1:0]  NOP_INSTR    = WORD_SIZE'(NOP_WORD)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        prog_we,
    input  logic [idx_width(DEPTH)-1:0] prog_addr,
    input  logic [WORD_SIZE-1:0]        prog_data,
    input  logic [len_width(DEPTH)-1:0] prog_len,
    input  logic                        start,
`ifdef IMEM_SEQ_LOOP_EN
    input  logic [7:0]                  loop_count,
    output logic [7:0]                  pass_idx,
`endif
    input  logic                        imem_resp_ready,
    output logic                        imem_resp_valid,
    output logic [WORD_SIZE-1:0]        imem_resp_bits_data,
    output logic                        busy,
    output logic                        done,
    output logic [idx_width(DEPTH)-1:0] pc_idx,
    output logic [15:0]                 issued_count
);

    localparam int unsigned IW  = idx_width(DEPTH);
    localparam int unsigned LW  = len_width(DEPTH);
    localparam int unsigned DCW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'((DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1);
    localparam logic [LW-1:0]  LEN_MAX    = LW'(DEPTH);

    seq_state_t           state, state_next;
    logic [LW-1:0]        len;
    logic [LW-1:0]        len_clamped;
    logic [DCW-1:0]       drain_cnt;
    logic [WORD_SIZE-1:0] mem_rdata;
    logic                 mem_we;
    logic                 idle_like;
    logic                 xfer;
    logic                 last_word;
    logic                 wrap;

    assign idle_like   = (state == ST_IDLE) || (state == ST_DONE);
    assign mem_we      = prog_we && idle_like;
    assign xfer        = imem_resp_valid && imem_resp_ready;
    assign last_word   = ({1'b0, pc_idx} == (len - LW'(1)));
    assign len_clamped = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;

`ifdef IMEM_SEQ_LOOP_EN
    logic [7:0] loops_left;
    assign wrap = (loops_left != 8'd0);
`else
    assign wrap = 1'b0;
`endif

    imem_seq_prog_mem #(
        .DEPTH     (DEPTH),
        .WORD_SIZE (WORD_SIZE)
    ) u_prog_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc_idx),
        .rdata (mem_rdata)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next = (prog_len == '0) ? ST_DRAIN : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (xfer && last_word && !wrap) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (DRAIN_CYCLES == 0) begin
                    state_next = ST_DONE;
                end else if (xfer && (drain_cnt == DRAIN_LAST)) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Port-facing outputs decoded from state. With no drain configured, valid stays
    // low for the single pass-through DRAIN cycle so no phantom transfer is counted.
    always_comb begin
        imem_resp_valid     = 1'b0;
        imem_resp_bits_data = NOP_INSTR;
        busy                = 1'b0;
        done                = 1'b0;
        case (state)
            ST_ISSUE: begin
                imem_resp_valid     = 1'b1;
                imem_resp_bits_data = mem_rdata;
                busy                = 1'b1;
            end
            ST_DRAIN: begin
                imem_resp_valid = (DRAIN_CYCLES != 0);
                busy            = 1'b1;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Program index, drain progress, pass tracking and the saturating transfer count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_idx       <= '0;
            len          <= '0;
            drain_cnt    <= '0;
            issued_count <= '0;
`ifdef IMEM_SEQ_LOOP_EN
            loops_left   <= '0;
            pass_idx     <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        len          <= len_clamped;
                        pc_idx       <= '0;
                        drain_cnt    <= '0;
                        issued_count <= '0;
`ifdef IMEM_SEQ_LOOP_EN
                        loops_left   <= loop_count;
                        pass_idx     <= '0;
`endif
                    end
                end
                ST_ISSUE: begin
                    if (xfer) begin
                        if (last_word) begin
                            pc_idx <= '0;
`ifdef IMEM_SEQ_LOOP_EN
                            if (wrap) begin
                                loops_left <= loops_left - 8'd1;
                                pass_idx   <= pass_idx + 8'd1;
                            end
`endif
                        end else begin
                            pc_idx <= pc_idx + IW'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (xfer) begin
                        drain_cnt <= drain_cnt + DCW'(1);
                    end
                end
                default: ;
            endcase
            if (xfer && (issued_count != 16'hFFFF)) begin
                issued_count <= issued_count + 16'd1;
            end
        end
    end

endmodule
